// File: rtl/sdram_arb_pkg.sv
// Shared types and width helpers for the SDRAM port arbiter.
//   owner_t   : registered bus owner; its encoding doubles as the one-hot grant.
//   req_id_t  : requester id stored in the read-tag FIFO (0 = VGA, 1 = draw/CPU).
//   be_w()    : byteenable width for a given data width.
//   cnt_w()   : bits needed to hold values 0..max_val.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN0     = 2'b01,
        OWN1     = 2'b10
    } owner_t;

    typedef logic req_id_t;

    localparam req_id_t ID_S0 = 1'b0;
    localparam req_id_t ID_S1 = 1'b1;

    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// In-order tag FIFO recording which requester issued each outstanding read.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   push       : store push_id at the tail
//   push_id    : requester id of the accepted read
//   pop        : discard the head entry (read data returned)
//   full/empty : occupancy flags
//   head       : requester id of the oldest outstanding read
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output req_id_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    req_id_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller's single Avalon-MM master port between the
// VGA scan-out reader (s0, read-only, high priority) and the draw/CPU path
// (s1, read/write, low priority with aging). Grants are held for bursts of
// up to BURST_LEN accepted beats; read data is routed back in order via a
// tag FIFO.
//   clk, reset        : clock, synchronous active-high reset
//   s0_*              : VGA requester slave port (read only)
//   s1_*              : draw/CPU requester slave port
//   m_*               : master port towards the SDRAM controller
//   grant             : one-hot current owner {s1,s0}, 00 = none
//   orphan_err        : sticky, read data returned with nothing outstanding
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int ADDR_W      = 25,
    parameter  int DATA_W      = 16,
    parameter  int BURST_LEN   = 8,
    parameter  int MAX_WAIT    = 64,
    parameter  int MAX_PENDING = 8,
    localparam int BE_W        = be_w(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,

    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [DATA_W-1:0] s1_writedata,
    input  logic [BE_W-1:0]   s1_byteenable,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    output logic [BE_W-1:0]   m_byteenable,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,

    output logic [1:0]        grant,
    output logic              orphan_err
);

    localparam int BC_W = cnt_w(BURST_LEN);
    localparam int WC_W = cnt_w(MAX_WAIT);
    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BURST_LEN - 1);
    localparam logic [WC_W-1:0] WAIT_MAX  = WC_W'(MAX_WAIT);

    owner_t          owner;
    owner_t          owner_nxt;
    req_id_t         last_id;
    req_id_t         cur_id;
    logic [BC_W-1:0] beat_cnt;
    logic [WC_W-1:0] wait_cnt;

    logic    s0_act;
    logic    s1_act;
    logic    s1_rd_only;
    logic    own_act;
    logic    own_rd;
    logic    own_wr;
    logic    rd_block;
    logic    accept;
    logic    decide;

    logic    fifo_push;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    req_id_t fifo_head;

    assign s0_act     = s0_read;
    assign s1_act     = s1_read | s1_write;
    // A simultaneous read+write from s1 is issued as a write only.
    assign s1_rd_only = s1_read & ~s1_write;

    always_comb begin
        own_act = 1'b0;
        own_rd  = 1'b0;
        own_wr  = 1'b0;
        case (owner)
            OWN0: begin
                own_act = s0_act;
                own_rd  = s0_read;
            end
            OWN1: begin
                own_act = s1_act;
                own_rd  = s1_rd_only;
                own_wr  = s1_write;
            end
            default: ;
        endcase
    end

    // With the FIFO full a read may still go out if a tag retires this cycle.
    assign rd_block = fifo_full & ~m_readdatavalid;

    assign m_read  = own_rd & ~rd_block;
    assign m_write = own_wr;
    assign accept  = (m_read | m_write) & ~m_waitrequest;

    assign s0_waitrequest = ~((owner == OWN0) & ~m_waitrequest & ~(own_rd & rd_block));
    assign s1_waitrequest = ~((owner == OWN1) & ~m_waitrequest & ~(own_rd & rd_block));

    // With no owner the data-path mux keeps pointing at the previous owner.
    assign cur_id = (owner == OWN1) ? ID_S1 :
                    (owner == OWN0) ? ID_S0 : last_id;

    assign m_address    = (cur_id == ID_S1) ? s1_address : s0_address;
    assign m_writedata  = s1_writedata;
    assign m_byteenable = (cur_id == ID_S1) ? s1_byteenable : {BE_W{1'b1}};

    assign fifo_push = accept & m_read;
    assign fifo_pop  = m_readdatavalid & ~fifo_empty;

    assign s0_readdatavalid = fifo_pop & (fifo_head == ID_S0);
    assign s1_readdatavalid = fifo_pop & (fifo_head == ID_S1);
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;

    assign grant = owner;

    // Re-arbitrate when idle, when the owner drops its request, or on the
    // last beat of a burst (the new owner then follows without a bubble).
    assign decide = (owner == OWN_NONE) | ~own_act | (accept & (beat_cnt == BEAT_LAST));

    always_comb begin
        if ((wait_cnt == WAIT_MAX) && s1_act) begin
            owner_nxt = OWN1;
        end else if (s0_act) begin
            owner_nxt = OWN0;
        end else if (s1_act) begin
            owner_nxt = OWN1;
        end else begin
            owner_nxt = OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_NONE;
            last_id    <= ID_S0;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (decide) begin
                owner    <= owner_nxt;
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (owner != OWN_NONE) begin
                last_id <= cur_id;
            end

            if (decide && (owner_nxt == OWN1)) begin
                wait_cnt <= '0;
            end else if (s1_act && (owner != OWN1) && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (m_readdatavalid && fifo_empty) begin
                orphan_err <= 1'b1;
            end
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_PENDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .push_id (cur_id),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a vector table for single-cycle
// behaviour plus hand-written multi-cycle sequences (bursts, aging, response
// routing, full-FIFO stall, read+write collision, reset with reads in flight).
module tb_sdram_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int BE_W   = 2;
    localparam int LAT    = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] s0_address;
    logic              s0_read;
    logic              s0_waitrequest;
    logic [DATA_W-1:0] s0_readdata;
    logic              s0_readdatavalid;
    logic [ADDR_W-1:0] s1_address;
    logic              s1_read;
    logic              s1_write;
    logic [DATA_W-1:0] s1_writedata;
    logic [BE_W-1:0]   s1_byteenable;
    logic              s1_waitrequest;
    logic [DATA_W-1:0] s1_readdata;
    logic              s1_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic [BE_W-1:0]   m_byteenable;
    logic              m_waitrequest;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic [1:0]        grant;
    logic              orphan_err;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BURST_LEN   (8),
        .MAX_WAIT    (64),
        .MAX_PENDING (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s0_address       (s0_address),
        .s0_read          (s0_read),
        .s0_waitrequest   (s0_waitrequest),
        .s0_readdata      (s0_readdata),
        .s0_readdatavalid (s0_readdatavalid),
        .s1_address       (s1_address),
        .s1_read          (s1_read),
        .s1_write         (s1_write),
        .s1_writedata     (s1_writedata),
        .s1_byteenable    (s1_byteenable),
        .s1_waitrequest   (s1_waitrequest),
        .s1_readdata      (s1_readdata),
        .s1_readdatavalid (s1_readdatavalid),
        .m_address        (m_address),
        .m_read           (m_read),
        .m_write          (m_write),
        .m_writedata      (m_writedata),
        .m_byteenable     (m_byteenable),
        .m_waitrequest    (m_waitrequest),
        .m_readdata       (m_readdata),
        .m_readdatavalid  (m_readdatavalid),
        .grant            (grant),
        .orphan_err       (orphan_err)
    );

    // exp = {grant[1:0], m_read, m_write, s0_wr, s1_wr, s0_rdv, s1_rdv, orphan}
    typedef struct {
        logic       s0r;
        logic       s1r;
        logic       s1w;
        logic       mwr;
        logic       rdv;
        logic [8:0] exp;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;
    int data_bad = 0;
    int rdv_log[$];

    bit          resp_en;
    logic [7:0]  pipe;

    logic [1:0]        sn_grant;
    logic              sn_mr, sn_mw, sn_w0, sn_w1, sn_r0, sn_r1, sn_or, sn_rdacc;
    logic [ADDR_W-1:0] sn_addr;
    logic [DATA_W-1:0] sn_wdata;
    logic [BE_W-1:0]   sn_be;

    logic [1:0] ghist [160];
    int         n, bad, first1, run1, second1;
    logic [9:0] pat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: sample outputs mid-cycle, then advance past the edge and
    // update the optional fixed-latency read responder.
    task automatic step();
        @(negedge clk);
        sn_grant = grant;
        sn_mr    = m_read;
        sn_mw    = m_write;
        sn_w0    = s0_waitrequest;
        sn_w1    = s1_waitrequest;
        sn_r0    = s0_readdatavalid;
        sn_r1    = s1_readdatavalid;
        sn_or    = orphan_err;
        sn_addr  = m_address;
        sn_wdata = m_writedata;
        sn_be    = m_byteenable;
        sn_rdacc = m_read & ~m_waitrequest;
        if (s0_readdatavalid) begin
            rdv_log.push_back(0);
            if (s0_readdata !== m_readdata) data_bad++;
        end
        if (s1_readdatavalid) begin
            rdv_log.push_back(1);
            if (s1_readdata !== m_readdata) data_bad++;
        end
        @(posedge clk);
        #1;
        if (resp_en) begin
            pipe = {pipe[6:0], sn_rdacc};
            m_readdatavalid = pipe[LAT-1];
            if (pipe[LAT-1]) m_readdata = m_readdata + 16'h0101;
        end
    endtask

    task automatic do_reset();
        resp_en         = 1'b0;
        pipe            = '0;
        reset           = 1'b1;
        s0_read         = 1'b0;
        s1_read         = 1'b0;
        s1_write        = 1'b0;
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        step();
        step();
        reset = 1'b0;
        rdv_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0_0_1_1_0_0_0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0_0_1_1_0_0_0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b01_1_0_1_1_0_0_0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b01_1_0_0_1_0_0_0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'b01_0_0_0_1_0_0_0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 9'b10_0_1_1_1_0_0_0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 9'b10_0_1_1_0_0_0_0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'b10_1_0_1_0_0_0_0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b10_0_0_1_0_1_0_0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b00_0_0_1_1_0_1_0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b00_0_0_1_1_0_0_0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0_0_1_1_0_0_1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'b00_0_0_1_1_0_0_1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 9'b01_1_0_1_1_0_0_1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b01_1_0_0_1_0_0_1};

        s0_address    = 25'h0AAAA5;
        s1_address    = 25'h155550;
        s1_writedata  = 16'hBEEF;
        s1_byteenable = 2'b10;
        m_readdata    = 16'h1234;

        // Vector table, starting from reset.
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            s0_read         = vecs[i].s0r;
            s1_read         = vecs[i].s1r;
            s1_write        = vecs[i].s1w;
            m_waitrequest   = vecs[i].mwr;
            m_readdatavalid = vecs[i].rdv;
            step();
            chk($sformatf("vec%0d", i),
                {sn_grant, sn_mr, sn_mw, sn_w0, sn_w1, sn_r0, sn_r1, sn_or}, vecs[i].exp);
        end

        // s0 alone: 20 back-to-back reads across burst boundaries.
        do_reset();
        resp_en = 1'b1;
        s0_read = 1'b1;
        step();
        chk("burst_first_cycle", {sn_grant, sn_mr}, 3'b00_0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!(sn_grant == 2'b01 && sn_mr && !sn_w0)) bad++;
            if (i == 3) chk("burst_s0_addr", sn_addr, s0_address);
        end
        chk("burst_bubbles", bad, 0);
        s0_read = 1'b0;
        step();
        chk("burst_stop", sn_mr, 1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("burst_returns", rdv_log.size(), 20);

        // Aging: both continuously active.
        do_reset();
        resp_en  = 1'b1;
        s0_read  = 1'b1;
        s1_write = 1'b1;
        for (int c = 0; c < 160; c++) begin
            step();
            ghist[c] = sn_grant;
        end
        s0_read  = 1'b0;
        s1_write = 1'b0;
        first1 = -1;
        for (int c = 0; c < 160; c++) if (first1 < 0 && ghist[c] == 2'b10) first1 = c;
        chk("aging_first_grant", first1, 65);
        run1 = 0;
        second1 = -1;
        if (first1 >= 0) begin
            while (first1 + run1 < 160 && ghist[first1 + run1] == 2'b10) run1++;
            chk("aging_hold_len", run1, 8);
            if (first1 + run1 < 160) chk("aging_s0_regains", ghist[first1 + run1], 2'b01);
            for (int c = first1 + run1; c < 160; c++)
                if (second1 < 0 && ghist[c] == 2'b10) second1 = c;
        end
        chk("aging_second_grant", second1, 145);
        for (int i = 0; i < 8; i++) step();

        // Response routing: 8 s0 reads then 2 s1 reads, latency 5.
        do_reset();
        resp_en = 1'b1;
        s0_read = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && n < 8; i++) begin
            step();
            if (sn_rdacc) n++;
        end
        s0_read = 1'b0;
        s1_read = 1'b1;
        n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            step();
            if (sn_rdacc) n++;
        end
        chk("route_s1_issued", n, 2);
        s1_read = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("route_count", rdv_log.size(), 10);
        pat = '0;
        for (int i = 0; i < rdv_log.size() && i < 10; i++) pat[i] = rdv_log[i][0];
        chk("route_order", pat, 10'b11_0000_0000);
        chk("route_data", data_bad, 0);

        // Full tag FIFO: 9th read waits for the first return.
        do_reset();
        s0_read = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 8; i++) begin
            step();
            if (sn_rdacc) n++;
        end
        chk("stall_fill", n, 8);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (!(sn_mr == 1'b0 && sn_w0 == 1'b1)) bad++;
        end
        chk("stall_hold", bad, 0);
        m_readdatavalid = 1'b1;
        step();
        m_readdatavalid = 1'b0;
        chk("stall_pop_accept", {sn_mr, sn_w0, sn_r0}, 3'b101);
        step();
        chk("stall_reblock", {sn_mr, sn_w0}, 2'b01);
        m_readdatavalid = 1'b1;
        step();
        chk("stall_tenth", {sn_mr, sn_w0, sn_r0}, 3'b101);
        s0_read = 1'b0;
        for (int i = 0; i < 8; i++) step();
        m_readdatavalid = 1'b0;
        chk("stall_drained", rdv_log.size(), 10);
        step();
        chk("stall_no_orphan", sn_or, 1'b0);

        // s1 read+write together: write only, no tag, waitrequest honoured.
        do_reset();
        s1_read       = 1'b1;
        s1_write      = 1'b1;
        m_waitrequest = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            m_waitrequest = (i % 2 == 1);
            step();
            chk($sformatf("rw_cycle%0d", i), {sn_grant, sn_mr, sn_mw, sn_w1},
                {2'b10, 1'b0, 1'b1, m_waitrequest});
        end
        chk("rw_mux", {sn_addr, sn_wdata, sn_be}, {s1_address, s1_writedata, s1_byteenable});
        s1_read         = 1'b0;
        s1_write        = 1'b0;
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b1;
        step();
        m_readdatavalid = 1'b0;
        chk("rw_no_tag_rdv", {sn_r0, sn_r1}, 2'b00);
        step();
        chk("rw_no_tag_orphan", sn_or, 1'b1);

        // Reset with 3 reads in flight, then late responses.
        do_reset();
        s0_read = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            step();
            if (sn_rdacc) n++;
        end
        s0_read = 1'b0;
        reset   = 1'b1;
        step();
        step();
        reset = 1'b0;
        rdv_log.delete();
        step();
        chk("rst_grant", {sn_grant, sn_mr, sn_w0, sn_or}, 5'b00_0_1_0);
        m_readdatavalid = 1'b1;
        step();
        chk("rst_orphan_before", sn_or, 1'b0);
        step();
        chk("rst_orphan_after", sn_or, 1'b1);
        step();
        m_readdatavalid = 1'b0;
        step();
        chk("rst_no_rdv", rdv_log.size(), 0);
        chk("rst_orphan_sticky", sn_or, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single Avalon-MM master port of the SDRAM controller between two requesters.
- Requester 0 is the VGA scan-out reader. It is read-only and has high priority.
- Requester 1 is the draw/CPU path. It issues reads and writes at low priority and has anti-starvation aging.
- The block holds grants for short bursts and routes pipelined read data back to the issuer through an in-order tag FIFO.

Parameters:
- ADDR_W, 25: word address width.
- DATA_W, 16: data width; byteenable width is DATA_W/8.
- BURST_LEN, 8: maximum accepted beats per grant before forced re-arbitration (1..255).
- MAX_WAIT, 64: cycles requester 1 may wait before it overrides requester 0 (1..1023).
- MAX_PENDING, 8: outstanding reads tracked (power of 2, ≥2).

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high.
- s0_address in ADDR_W; s0_read in 1; s0_waitrequest out 1; s0_readdata out DATA_W; s0_readdatavalid out 1.
- s1_address in ADDR_W; s1_read in 1; s1_write in 1; s1_writedata in DATA_W; s1_byteenable in DATA_W/8.
- s1_waitrequest out 1; s1_readdata out DATA_W; s1_readdatavalid out 1.
- m_address out ADDR_W; m_read out 1; m_write out 1; m_writedata out DATA_W; m_byteenable out DATA_W/8.
- m_waitrequest in 1; m_readdata in DATA_W; m_readdatavalid in 1.
- grant out 2: one-hot current owner ({s1,s0}); 00 = none.
- orphan_err out 1: sticky; set when read data returns with nothing outstanding.

Behaviour:
- Reset values:
  - grant=00, m_read=0, m_write=0.
  - s0_waitrequest=1, s1_waitrequest=1, s*_readdatavalid=0.
  - orphan_err=0, beat_cnt=0, wait_cnt=0, tag FIFO empty.
  - Reset mid-operation drops all pending tags. SDRAM responses arriving after reset with an empty FIFO set orphan_err.
- Owner register: NONE/OWN0/OWN1; grant mirrors it.
- Master outputs are a combinational mux of the owner's signals.
  - When the owner is NONE, m_read=m_write=0.
  - Other m_* outputs hold the last owner's values (don't-care).
- Requester "active" means s0_read, or s1_read|s1_write.
  - If s1_read and s1_write are both asserted, it is treated as a write; m_read=0.
- Accept: a cycle where owner active, master command asserted, and m_waitrequest=0.
  - Owner's waitrequest = ~accept-eligible, i.e. 1 unless owner and ~m_waitrequest and not read-blocked.
  - The non-owner's waitrequest is always 1.
- Read block: if FIFO full, the owner's read is not forwarded (m_read=0) and its waitrequest=1. Writes are unaffected.
- Decision cycle: owner==NONE, OR owner not active, OR (accept and beat_cnt==BURST_LEN-1).
  - Priority: if wait_cnt==MAX_WAIT and s1 active → OWN1.
  - Else s0 active → OWN0.
  - Else s1 active → OWN1.
  - Else NONE.
  - The new owner is registered and takes effect the next cycle. Handover has no bubble when release coincides with the last accepted beat.
- beat_cnt: cleared on owner change, +1 per accept.
- wait_cnt:
  - +1 (saturating at MAX_WAIT) each cycle s1 is active and owner≠OWN1.
  - Cleared when OWN1 is granted.
  - Held when s1 is idle.
- Tag FIFO:
  - Push owner id on each accepted read; pop on m_readdatavalid.
  - Simultaneous push/pop keeps occupancy constant.
- Response routing:
  - sX_readdatavalid = m_readdatavalid & (head==X) & ~empty, combinational (zero latency).
  - s0_readdata and s1_readdata both equal m_readdata.
  - m_readdatavalid with FIFO empty: dropped, orphan_err<=1 until reset.
- Writes push no tag.

Decomposition:
- Package sdram_arb_pkg:
  - owner enum (OWN_NONE, OWN0, OWN1).
  - Requester-id typedef (1 bit).
  - Width helpers: BE_W=DATA_W/8, counter widths via $clog2.
- Sub-module sdram_arb_tag_fifo: 1-bit wide, depth MAX_PENDING, sync reset, push/pop/full/empty/head.
- Owner FSM, counters and mux stay in the top.

Test Plan:
- Only s0 issues 20 back-to-back reads with m_waitrequest=0.
  - Required: grant=01 throughout. Re-arbitration every 8 accepts with no bubble cycles, so m_read is high for 20 consecutive cycles.
- s0 and s1 both continuously active, MAX_WAIT=64.
  - Required: s1 granted no later than 65 cycles after first request. It holds for 8 beats, then s0 regains the grant and wait_cnt restarts from 0.
- Controller read latency 5, s0 issues 8 reads, then s1 issues 2 reads.
  - Required: exactly 8 s0_readdatavalid pulses followed by 2 s1_readdatavalid pulses, data matching m_readdata.
- Stall returns with MAX_PENDING=8 and 10 reads issued.
  - Required: the 9th read is held (m_read=0, s*_waitrequest=1) until the first m_readdatavalid. Then it is accepted the same cycle as the pop.
- s1 asserts read and write together with m_waitrequest toggling.
  - Required: only m_write is asserted, no tag is pushed, and each write is accepted only on a cycle where m_waitrequest=0.
- Assert reset with 3 reads outstanding, then inject 3 m_readdatavalid pulses.
  - Required: no s*_readdatavalid, orphan_err=1 after the first pulse, grant=00 after reset.
